// File: rtl/mips_pkg.sv
// Shared multicycle-MIPS definitions: opcodes, control-FSM state encodings and
// select-field codes used by the control FSM and the ALU decoder.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU decoder class: add for address/increment, subtract for compare, funct-driven
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_is_legal(input logic [5:0] op);
      logic legal;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
         default:                                       legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: Moore-style decode of datapath selects and
// enables from the current state, with optional memory handshake on wait states.
module mc_control_fsm
   import mips_pkg::*;
#(
   parameter bit MEM_HS = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_r;
   state_t next_state_s;
   logic   mem_ok_s;

   logic   ir_write_s;
   logic   pc_write_s;
   logic   branch_s;
   logic   reg_write_s;
   logic   mem_write_s;
   logic   illegal_s;

   assign mem_ok_s = MEM_HS ? mem_ready : 1'b1;

   // State register with synchronous reset to FETCH
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; op is consulted only in DECODE and MEMADR
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH: begin
            if (mem_ok_s) begin
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state_s = S_MEMADR;
               OP_RTYPE:     next_state_s = S_EXECUTE;
               OP_BEQ:       next_state_s = S_BEQEX;
               OP_ADDI:      next_state_s = S_ADDIEX;
               OP_J:         next_state_s = S_JEX;
               default:      next_state_s = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               next_state_s = S_MEMRD;
            end else begin
               next_state_s = S_MEMWR;
            end
         end
         S_MEMRD: begin
            if (mem_ok_s) begin
               next_state_s = S_MEMWB;
            end else begin
               next_state_s = S_MEMRD;
            end
         end
         S_MEMWR: begin
            if (mem_ok_s) begin
               next_state_s = S_FETCH;
            end else begin
               next_state_s = S_MEMWR;
            end
         end
         S_MEMWB:   next_state_s = S_FETCH;
         S_EXECUTE: next_state_s = S_ALUWB;
         S_ALUWB:   next_state_s = S_FETCH;
         S_BEQEX:   next_state_s = S_FETCH;
         S_ADDIEX:  next_state_s = S_ADDIWB;
         S_ADDIWB:  next_state_s = S_FETCH;
         S_JEX:     next_state_s = S_FETCH;
         default:   next_state_s = S_FETCH;
      endcase
   end

   // Output decode from state; unlisted outputs stay at zero
   always_comb begin
      IorD        = 1'b0;
      ALUSrcA     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcB     = SRCB_REG;
      PCSrc       = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      branch_s    = 1'b0;
      reg_write_s = 1'b0;
      mem_write_s = 1'b0;
      illegal_s   = 1'b0;
      case (state_r)
         S_FETCH: begin
            ALUSrcB    = SRCB_FOUR;
            ir_write_s = mem_ok_s;
            pc_write_s = mem_ok_s;
         end
         S_DECODE: begin
            ALUSrcB   = SRCB_BOFF;
            illegal_s = ~op_is_legal(op);
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            IorD = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg    = 1'b1;
            reg_write_s = 1'b1;
         end
         S_MEMWR: begin
            IorD        = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegDst      = 1'b1;
            reg_write_s = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_SUB;
            PCSrc    = PCSRC_ALUOUT;
            branch_s = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB: begin
            reg_write_s = 1'b1;
         end
         S_JEX: begin
            PCSrc      = PCSRC_JUMP;
            pc_write_s = 1'b1;
         end
         default: begin
            IorD = 1'b0;
         end
      endcase
   end

   // Enables and the illegal pulse are suppressed for the whole reset window,
   // so an interrupted store never issues another write
   assign IRWrite    = ir_write_s  & ~rst;
   assign PCWrite    = pc_write_s  & ~rst;
   assign Branch     = branch_s    & ~rst;
   assign RegWrite   = reg_write_s & ~rst;
   assign MemWrite   = mem_write_s & ~rst;
   assign illegal_op = illegal_s   & ~rst;
   assign state      = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each cycle's expected output vector is
// queued when stimulus is applied and compared when the outputs settle.
module tb_mc_control_fsm;

   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;
   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] ADDI  = 6'b001000;
   localparam logic [5:0] JMP   = 6'b000010;
   localparam logic [5:0] BAD   = 6'b111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       mem_ready;

   logic       IorD, ALUSrcA, RegDst, MemtoReg;
   logic [1:0] ALUSrcB, PCSrc, ALUOp;
   logic       IRWrite, PCWrite, Branch, RegWrite, MemWrite, illegal_op;
   logic [3:0] state;

   logic       IorD2, ALUSrcA2, RegDst2, MemtoReg2;
   logic [1:0] ALUSrcB2, PCSrc2, ALUOp2;
   logic       IRWrite2, PCWrite2, Branch2, RegWrite2, MemWrite2, illegal_op2;
   logic [3:0] state2;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_step   = 0;

   string       tag_q[$];
   logic [19:0] exp_q[$];

   mc_control_fsm #(.MEM_HS(1'b1)) dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_op(illegal_op),
      .state(state)
   );

   mc_control_fsm #(.MEM_HS(1'b0)) dut_nohs (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .IorD(IorD2), .ALUSrcA(ALUSrcA2), .RegDst(RegDst2), .MemtoReg(MemtoReg2),
      .ALUSrcB(ALUSrcB2), .PCSrc(PCSrc2), .ALUOp(ALUOp2),
      .IRWrite(IRWrite2), .PCWrite(PCWrite2), .Branch(Branch2),
      .RegWrite(RegWrite2), .MemWrite(MemWrite2), .illegal_op(illegal_op2),
      .state(state2)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected outputs for a state, straight from the per-state output table
   function automatic logic [19:0] ref_out(input logic [3:0] st, input logic mr,
                                           input logic [5:0] o, input logic r);
      logic       iord, srca, regdst, m2r, irw, pcw, br, rw, mw, ill;
      logic [1:0] srcb, pcsrc, aluop;
      {iord, srca, regdst, m2r, irw, pcw, br, rw, mw, ill} = 10'd0;
      srcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
      case (st)
         4'd0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
         4'd1:  begin srcb = 2'b11;
                      ill = !(o == LW || o == SW || o == RTYPE || o == BEQ || o == ADDI || o == JMP); end
         4'd2:  begin srca = 1'b1; srcb = 2'b10; end
         4'd3:  begin iord = 1'b1; end
         4'd4:  begin m2r = 1'b1; rw = 1'b1; end
         4'd5:  begin iord = 1'b1; mw = 1'b1; end
         4'd6:  begin srca = 1'b1; aluop = 2'b10; end
         4'd7:  begin regdst = 1'b1; rw = 1'b1; end
         4'd8:  begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; br = 1'b1; end
         4'd9:  begin srca = 1'b1; srcb = 2'b10; end
         4'd10: begin rw = 1'b1; end
         4'd11: begin pcsrc = 2'b10; pcw = 1'b1; end
         default: begin end
      endcase
      if (r) {irw, pcw, br, rw, mw, ill} = 6'd0;
      return {st, iord, srca, regdst, m2r, srcb, pcsrc, aluop, irw, pcw, br, rw, mw, ill};
   endfunction

   // One clock cycle: drive inputs, queue the expectation, compare once settled
   task automatic step(input string name, input logic r, input logic [5:0] o,
                       input logic mr, input logic [3:0] es);
      logic [19:0] obs;
      logic [19:0] exp;
      string       t;
      @(negedge clk);
      rst = r; op = o; mem_ready = mr;
      n_step++;
      tag_q.push_back($sformatf("%s#%0d", name, n_step));
      exp_q.push_back(ref_out(es, mr, o, r));
      #2;
      obs = {state, IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp,
             IRWrite, PCWrite, Branch, RegWrite, MemWrite, illegal_op};
      t   = tag_q.pop_front();
      exp = exp_q.pop_front();
      check_eq(t, {12'd0, obs}, {12'd0, exp});
   endtask

   initial begin
      rst = 1'b1; op = RTYPE; mem_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);

      step("rst_hold", 1'b1, RTYPE, 1'b1, 4'd0);

      // FETCH stall: handshake instance holds, no-handshake instance advances
      step("fetch_wait", 1'b0, JMP, 1'b0, 4'd0);
      check_eq("nohs_fetch_irw", {31'd0, IRWrite2}, 32'd1);
      step("fetch_wait", 1'b0, JMP, 1'b0, 4'd0);
      check_eq("nohs_state", {28'd0, state2}, 32'd1);
      step("fetch_wait", 1'b0, JMP, 1'b1, 4'd0);
      step("j_dec",      1'b0, JMP, 1'b1, 4'd1);
      step("j_ex",       1'b0, JMP, 1'b1, 4'd11);

      // LW, no waits
      step("lw", 1'b0, LW, 1'b1, 4'd0);
      step("lw", 1'b0, LW, 1'b1, 4'd1);
      step("lw", 1'b0, LW, 1'b1, 4'd2);
      step("lw", 1'b0, LW, 1'b1, 4'd3);
      step("lw", 1'b0, LW, 1'b1, 4'd4);

      // LW with one read wait; op changes outside DECODE/MEMADR are ignored
      step("lw_w", 1'b0, LW,  1'b1, 4'd0);
      step("lw_w", 1'b0, LW,  1'b1, 4'd1);
      step("lw_w", 1'b0, LW,  1'b1, 4'd2);
      step("lw_w", 1'b0, JMP, 1'b0, 4'd3);
      step("lw_w", 1'b0, SW,  1'b1, 4'd3);
      step("lw_w", 1'b0, JMP, 1'b1, 4'd4);

      // SW with three wait cycles in MEMWR
      step("sw", 1'b0, SW, 1'b1, 4'd0);
      step("sw", 1'b0, SW, 1'b1, 4'd1);
      step("sw", 1'b0, SW, 1'b1, 4'd2);
      step("sw", 1'b0, SW, 1'b0, 4'd5);
      step("sw", 1'b0, SW, 1'b0, 4'd5);
      step("sw", 1'b0, SW, 1'b0, 4'd5);
      step("sw", 1'b0, SW, 1'b1, 4'd5);

      step("rtype", 1'b0, RTYPE, 1'b1, 4'd0);
      step("rtype", 1'b0, RTYPE, 1'b1, 4'd1);
      step("rtype", 1'b0, RTYPE, 1'b1, 4'd6);
      step("rtype", 1'b0, RTYPE, 1'b1, 4'd7);

      step("beq", 1'b0, BEQ, 1'b1, 4'd0);
      step("beq", 1'b0, BEQ, 1'b1, 4'd1);
      step("beq", 1'b0, BEQ, 1'b1, 4'd8);

      step("addi", 1'b0, ADDI, 1'b1, 4'd0);
      step("addi", 1'b0, ADDI, 1'b1, 4'd1);
      step("addi", 1'b0, ADDI, 1'b1, 4'd9);
      step("addi", 1'b0, ADDI, 1'b1, 4'd10);

      step("illegal", 1'b0, BAD, 1'b1, 4'd0);
      step("illegal", 1'b0, BAD, 1'b1, 4'd1);
      step("illegal", 1'b0, BAD, 1'b1, 4'd0);
      step("illegal", 1'b0, BAD, 1'b1, 4'd1);

      // Reset in the middle of a stalled store
      step("rst_sw", 1'b0, SW, 1'b1, 4'd0);
      step("rst_sw", 1'b0, SW, 1'b1, 4'd1);
      step("rst_sw", 1'b0, SW, 1'b1, 4'd2);
      step("rst_sw", 1'b0, SW, 1'b0, 4'd5);
      step("rst_sw", 1'b1, SW, 1'b0, 4'd5);
      step("rst_sw", 1'b1, SW, 1'b0, 4'd0);
      step("rst_sw", 1'b0, SW, 1'b1, 4'd0);
      step("rst_sw", 1'b0, SW, 1'b1, 4'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
